bounce_generator: RTL
=====================

# bounce_generator

Synthesizable switch-bounce emulator: turns a clean level command into a realistic bouncing mechanical-contact waveform. Used on-chip as a stimulus source for the button debouncer, for self-test and bring-up without physical buttons. Bounce segment widths come from a free-running LFSR, so the same seed always reproduces the same waveform.

## Interface
- NUM_BOUNCES, default 4: number of extra return-and-reassert pairs per transition. 0 is legal.
- SEG_W, default 8: segment-length width. Each segment lasts `lfsr[SEG_W-1:0] + 1` cycles (range 1..2^SEG_W). Legal range 1..16.
- SETTLE, default 2000000: number of cycles `out` is held stable after the last bounce edge. Must be ≥ 1.
- SEED, default 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'h0001.
- clk  input  1  single clock; all logic is on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- cmd  input  1  clean target level requested by the test controller.
- out  output  1  bouncing contact level; drives the debouncer input.
- busy  output  1  high while a transition is being emulated (BOUNCE or SETTLE).
- done  output  1  one-cycle pulse when a transition completes.

## Operation
- Registers:
  - state: IDLE, BOUNCE or SETTLE.
  - level: the committed stable level.
  - target: the latched `cmd` value.
  - lfsr[15:0].
  - seg_cnt[SEG_W:0].
  - edge_cnt: wide enough for 2*NUM_BOUNCES.
  - settle_cnt: ceil(log2(SETTLE+1)) bits.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every cycle in every state (free-running from reset).
- IDLE:
  - out = level, busy = 0.
  - If cmd != level: target <= cmd, out <= cmd (first edge), seg_cnt <= lfsr[SEG_W-1:0]+1, edge_cnt <= 0.
  - Next state is BOUNCE if NUM_BOUNCES > 0, otherwise SETTLE with settle_cnt <= 0.
- BOUNCE:
  - seg_cnt decrements each cycle.
  - In the cycle seg_cnt == 1: toggle out, increment edge_cnt, reload seg_cnt from the current lfsr.
  - When the toggle brings edge_cnt to 2*NUM_BOUNCES, out equals target. Go to SETTLE with settle_cnt <= 0.
- SETTLE:
  - out is held at target; settle_cnt increments each cycle.
  - In the cycle settle_cnt == SETTLE-1: level <= target, done <= 1, go to IDLE.
- cmd is ignored during BOUNCE and SETTLE. If cmd still differs from level once back in IDLE, a new transition starts.
- Edges per transition: exactly 2*NUM_BOUNCES+1 edges on out; the final value equals target.
- Falling and rising transitions are symmetric.

## Timing
- Reset values (asynchronous, while reset = 0):
  - state = IDLE, level = 0, out = 0, busy = 0, done = 0.
  - lfsr = SEED (or 1 if SEED is 0), seg_cnt = 0, edge_cnt = 0, settle_cnt = 0.
- Latency: out, busy and done are registered. First edge on out appears 1 cycle after cmd != level is sampled in IDLE; busy rises in the same cycle.
- Segment timing: segment k lasts exactly L_k = (LFSR value at load) + 1 cycles between consecutive out edges.
- SETTLE duration: exactly SETTLE cycles from the last out edge to the cycle done = 1.
- Completion cycle: done = 1 for exactly one cycle, with busy = 0 and state = IDLE in that same cycle.
- Back-to-back transition: if cmd != level during the done cycle, the next transition's first edge occurs in the following cycle. IDLE therefore lasts a minimum of 1 cycle.
- Total busy time = 1 + sum of 2*NUM_BOUNCES segment lengths + SETTLE − 1 cycles, counted from the first edge.
- Reset mid-operation (in BOUNCE or SETTLE): immediate return to the reset values. No done pulse; the transition is lost.
- Boundary conditions:
  - An all-ones segment field gives the maximum length 2^SEG_W.
  - seg_cnt is SEG_W+1 bits, so it cannot overflow.
  - The LFSR never reaches 0.

## Test plan
- Reset: hold reset = 0 with cmd = 1 → out = 0, busy = 0, done = 0 throughout. After release, first edge on out occurs 1 cycle after the first sampling edge.
- Rising transition (NUM_BOUNCES=2, SEG_W=2, SETTLE=10): cmd 0→1 → exactly 5 edges on out; each gap between edges is 1..4 cycles and matches a reference-model LFSR; out = 1 for 10 cycles, then a single done pulse; level = 1.
- No bounce (NUM_BOUNCES=0, SETTLE=10): cmd 1→0 → a single edge 1 cycle later; busy high for 10 cycles; done pulse; out stable at 0.
- cmd during busy: cmd toggles 1→0→1 mid-BOUNCE → waveform unchanged, ends at 1. Toggle cmd to 0 mid-SETTLE and hold it → new falling transition starts the cycle after done.
- Reset mid-BOUNCE: assert reset after the 2nd edge → out = 0, busy = 0 immediately; no done pulse. Re-run with the same cmd → identical waveform to the first run (seed determinism).
- End-to-end with the debouncer (its count window shorter than SETTLE): 3 press/release cycles → debouncer output shows exactly 3 clean high pulses, with no glitches during bounce.

Source files
------------

// File: rtl/bounce_generator.sv
// Switch-bounce emulator: turns a clean level command into a
// reproducible bouncing contact waveform driven by a free-running LFSR.
//
// Ports:
//   clk   - single clock, rising edge
//   reset - asynchronous active-low reset
//   cmd   - clean target level requested by the test controller
//   out   - bouncing contact level (registered)
//   busy  - high while a transition is being emulated (registered)
//   done  - one-cycle pulse when a transition completes (registered)
module bounce_generator #(
    parameter int unsigned NUM_BOUNCES = 4,
    parameter int unsigned SEG_W       = 8,
    parameter int unsigned SETTLE      = 2000000,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic clk,
    input  logic reset,
    input  logic cmd,
    output logic out,
    output logic busy,
    output logic done
);

    localparam int unsigned NE = 2 * NUM_BOUNCES;
    localparam int unsigned EW = ($clog2(NE + 1) < 1) ? 1 : $clog2(NE + 1);
    localparam int unsigned CW = ($clog2(SETTLE + 1) < 1) ? 1 : $clog2(SETTLE + 1);

    localparam logic [15:0]   SEED_EFF   = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [EW-1:0] LAST_EDGE  = EW'(NE);
    localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE - 1);
    localparam logic [SEG_W:0] SEG_ONE   = (SEG_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BOUNCE,
        S_SETTLE
    } state_e;

    state_e           state_q, state_d;
    logic             level_q, level_d;
    logic             target_q, target_d;
    logic             out_q, out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [SEG_W:0]   seg_q, seg_d;
    logic [EW-1:0]    edge_q, edge_d;
    logic [CW-1:0]    settle_q, settle_d;

    logic             start;
    logic             seg_hit;
    logic             last_toggle;
    logic             settle_end;
    logic [SEG_W:0]   seg_load;

    // Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1, runs in every state.
    assign lfsr_d = {lfsr_q[14:0],
                     lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Extra MSB keeps the all-ones field + 1 from wrapping to zero.
    assign seg_load    = {1'b0, lfsr_q[SEG_W-1:0]} + SEG_ONE;
    assign start       = (state_q == S_IDLE) && (cmd != level_q);
    assign seg_hit     = (seg_q == SEG_ONE);
    assign last_toggle = ((edge_q + EW'(1)) == LAST_EDGE);
    assign settle_end  = (settle_q == SETTLE_END);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            level_q  <= 1'b0;
            target_q <= 1'b0;
            out_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            lfsr_q   <= SEED_EFF;
            seg_q    <= '0;
            edge_q   <= '0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            target_q <= target_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            lfsr_q   <= lfsr_d;
            seg_q    <= seg_d;
            edge_q   <= edge_d;
            settle_q <= settle_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (NUM_BOUNCES > 0) ? S_BOUNCE : S_SETTLE;
                end
            end
            S_BOUNCE: begin
                if (seg_hit && last_toggle) begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_end) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        level_d  = level_q;
        target_d = target_q;
        out_d    = out_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        seg_d    = seg_q;
        edge_d   = edge_q;
        settle_d = settle_q;
        unique case (state_q)
            S_IDLE: begin
                out_d  = level_q;
                busy_d = 1'b0;
                if (start) begin
                    target_d = cmd;
                    out_d    = cmd;
                    busy_d   = 1'b1;
                    seg_d    = seg_load;
                    edge_d   = '0;
                    settle_d = '0;
                end
            end
            S_BOUNCE: begin
                busy_d = 1'b1;
                if (seg_hit) begin
                    out_d  = ~out_q;
                    edge_d = edge_q + EW'(1);
                    seg_d  = seg_load;
                    if (last_toggle) begin
                        settle_d = '0;
                    end
                end else begin
                    seg_d = seg_q - SEG_ONE;
                end
            end
            S_SETTLE: begin
                out_d = target_q;
                if (settle_end) begin
                    level_d = target_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    settle_d = settle_q + CW'(1);
                    busy_d   = 1'b1;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign out  = out_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
